// File: rtl/bcd_seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// bcd_seg7_scan_driver_if
// Groups the digit/load inputs and the segment/anode/tick outputs of the
// three-digit seven-segment scan driver.
//   hundreds/tens/ones : BCD digits from the upstream conversion stage
//   load               : capture strobe for all three digits
//   seg                : shared segment bus {g,f,e,d,c,b,a}
//   an                 : digit enables {hundreds,tens,ones}
//   frame_tick         : one-cycle pulse at the end of each 3-slot scan
// master = digit source / display consumer, slave = scan driver.
// -----------------------------------------------------------------------------
interface bcd_seg7_scan_driver_if;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       load;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  modport master (
    output hundreds, tens, ones, load,
    input  seg, an, frame_tick
  );

  modport slave (
    input  hundreds, tens, ones, load,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/bcd_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// bcd_seg7_scan_driver
// Time-multiplexed three-digit seven-segment driver. Latches BCD digits on a
// load strobe and scans them (ones, tens, hundreds) onto a shared segment bus
// with per-digit anode enables, ghost blanking at the start of each slot and
// optional leading-zero blanking.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of bcd_seg7_scan_driver_if (digits, load, seg, an,
//           frame_tick)
// Outputs are registered from the pre-edge counter/slot/latched digits, so the
// display lags the internal state by one cycle.
// -----------------------------------------------------------------------------
module bcd_seg7_scan_driver #(
  parameter int DIV_CNT     = 50000, // clock cycles per digit slot
  parameter int BLANK_CYC   = 500,   // all-off cycles at slot start (0 = none)
  parameter int SEG_ACT_LOW = 1,     // 1 = segments active-low
  parameter int AN_ACT_LOW  = 1,     // 1 = anodes active-low
  parameter int LZ_BLANK    = 1      // 1 = leading-zero blanking
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bcd_seg7_scan_driver_if.slave        bus
);

  localparam int                CNT_W    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CNT - 1);

  // Slot index encoding, in scan order.
  localparam logic [1:0] SLOT_ONES = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_HUNS = 2'd2;

  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = (AN_ACT_LOW  != 0) ? 3'b111 : 3'b000;

  // Active-high gfedcba pattern; codes above 9 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       hun_q, ten_q, one_q;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             tick_q, tick_d;

  logic [3:0]       digit;
  logic [2:0]       an_on;
  logic             slot_blank;
  logic             ghost_blank;

  // Compare at 32 bits so a zero BLANK_CYC simply never blanks.
  assign ghost_blank = (32'(cnt_q) < 32'(BLANK_CYC));

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    tick_d      = 1'b0;
    digit       = one_q;
    an_on       = 3'b000;
    slot_blank  = 1'b1;
    seg_d       = SEG_OFF;
    an_d        = AN_OFF;

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      idx_d  = (idx_q == SLOT_HUNS) ? SLOT_ONES : idx_q + 2'd1;
      tick_d = (idx_q == SLOT_HUNS);
    end

    // Leading-zero blanking only ever triggers on a latched 0, so error codes
    // (>9) are never hidden.
    case (idx_q)
      SLOT_ONES: begin
        digit      = one_q;
        an_on      = 3'b001;
        slot_blank = 1'b0;
      end
      SLOT_TENS: begin
        digit      = ten_q;
        an_on      = 3'b010;
        slot_blank = (LZ_BLANK != 0) && (hun_q == 4'd0) && (ten_q == 4'd0);
      end
      SLOT_HUNS: begin
        digit      = hun_q;
        an_on      = 3'b100;
        slot_blank = (LZ_BLANK != 0) && (hun_q == 4'd0);
      end
      default: ;  // unreachable slot index: stay dark
    endcase

    if (!ghost_blank && !slot_blank) begin
      seg_d = (SEG_ACT_LOW != 0) ? ~decode(digit) : decode(digit);
      an_d  = (AN_ACT_LOW  != 0) ? ~an_on         : an_on;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= SLOT_ONES;
      hun_q  <= 4'd0;
      ten_q  <= 4'd0;
      one_q  <= 4'd0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
      if (bus.load) begin
        hun_q <= bus.hundreds;
        ten_q <= bus.tens;
        one_q <= bus.ones;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule
